rv_iopmp_err_recorder: RTL and testbench

- Sits directly downstream of the IOPMP transaction checker.
- Consumes its per-transaction error capture outputs and latches the first violation into the ERR_REQINFO / ERR_REQID / ERR_REQADDR(H) register image.
- Holds one further violation in a shadow slot, counts any further drops, and raises the IOPMP interrupt.
- The register file reads the captured fields and drives the software clear strobes.

---
 rtl/rv_iopmp_err_recorder.sv | 159 +++++++++++++++
 tb/tb_rv_iopmp_err_recorder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_err_recorder.sv
// rtl/rv_iopmp_err_recorder.sv - IOPMP error capture: primary + shadow slot, saturating drop counter, irq.
// Optional capture timestamp enabled by defining IOPMP_ERR_TIMESTAMP_EN.
module rv_iopmp_err_recorder #(
  parameter int ADDR_WIDTH     = 64,
  parameter int SID_WIDTH      = 8,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      err_valid_i,
  input  logic [1:0]                err_ttype_i,
  input  logic [2:0]                err_etype_i,
  input  logic [SID_WIDTH-1:0]      err_sid_i,
  input  logic [15:0]               err_eid_i,
  input  logic [ADDR_WIDTH-1:0]     err_addr_i,
  input  logic                      ie_i,
  input  logic                      clr_ip_i,
  input  logic                      clr_cnt_i,
  output logic                      ip_o,
  output logic                      pend_o,
  output logic [1:0]                ttype_o,
  output logic [2:0]                etype_o,
  output logic [SID_WIDTH-1:0]      sid_o,
  output logic [15:0]               eid_o,
  output logic [31:0]               reqaddr_o,
  output logic [31:0]               reqaddrh_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
  output logic                      irq_o,
  output logic [31:0]               ts_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAP      = 2'd1,
    CAP_PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]            ttype;
    logic [2:0]            etype;
    logic [SID_WIDTH-1:0]  sid;
    logic [15:0]           eid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           ts;
  } slot_t;

  state_e                    state_q, state_d;
  slot_t                     prim_q, prim_d;
  slot_t                     shad_q, shad_d;
  slot_t                     new_slot;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      drop;

`ifdef IOPMP_ERR_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_cnt_q <= '0;
    else       ts_cnt_q <= ts_cnt_q + 32'd1;
  end
`endif

  always_comb begin
    new_slot.ttype = err_ttype_i;
    new_slot.etype = err_etype_i;
    new_slot.sid   = err_sid_i;
    new_slot.eid   = err_eid_i;
    new_slot.addr  = err_addr_i;
`ifdef IOPMP_ERR_TIMESTAMP_EN
    new_slot.ts    = ts_cnt_q;
`else
    new_slot.ts    = '0;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (err_valid_i) state_d = CAP;
      CAP: begin
        if (err_valid_i && !clr_ip_i)      state_d = CAP_PEND;
        else if (clr_ip_i && !err_valid_i) state_d = IDLE;
      end
      CAP_PEND: if (clr_ip_i && !err_valid_i) state_d = CAP;
      default:  state_d = IDLE;
    endcase
  end

  // Primary fields are zeroed whenever the slot empties so outputs read 0 in IDLE.
  always_comb begin
    prim_d = prim_q;
    shad_d = shad_q;
    drop   = 1'b0;
    unique case (state_q)
      IDLE: if (err_valid_i) prim_d = new_slot;
      CAP: begin
        if (clr_ip_i) prim_d = err_valid_i ? new_slot : '0;
        else if (err_valid_i) shad_d = new_slot;
      end
      CAP_PEND: begin
        if (clr_ip_i) begin
          prim_d = shad_q;
          shad_d = err_valid_i ? new_slot : '0;
        end else if (err_valid_i) begin
          drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_cnt_i)                      drop_cnt_d = drop ? DROP_CNT_WIDTH'(1) : '0;
    else if (drop && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prim_q     <= '0;
      shad_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      prim_q     <= prim_d;
      shad_q     <= shad_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FSM: outputs
  always_comb begin
    ip_o       = (state_q != IDLE);
    pend_o     = (state_q == CAP_PEND);
    irq_o      = ip_o & ie_i;
    ttype_o    = prim_q.ttype;
    etype_o    = prim_q.etype;
    sid_o      = prim_q.sid;
    eid_o      = prim_q.eid;
    reqaddr_o  = prim_q.addr[31:0];
    drop_cnt_o = drop_cnt_q;
    ts_o       = prim_q.ts;
  end

  generate
    if (ADDR_WIDTH > 32) begin : g_addrh
      assign reqaddrh_o = 32'(prim_q.addr[ADDR_WIDTH-1:32]);
    end else begin : g_no_addrh
      assign reqaddrh_o = '0;
    end
  endgenerate

endmodule

// File: tb/tb_rv_iopmp_err_recorder.sv
// tb/tb_rv_iopmp_err_recorder.sv - scoreboard bench for rv_iopmp_err_recorder against a queue-based model.
// Timestamp expectations are modelled when IOPMP_ERR_TIMESTAMP_EN is defined.
module tb_rv_iopmp_err_recorder;

  localparam int DCW     = 2;
  localparam int DCW_MAX = (1 << DCW) - 1;

  logic        clk = 1'b0;
  logic        rst, err_valid, ie, clr_ip, clr_cnt;
  logic [1:0]  err_ttype;
  logic [2:0]  err_etype;
  logic [7:0]  err_sid;
  logic [15:0] err_eid;
  logic [63:0] err_addr;
  logic        ip, pend, irq;
  logic [1:0]  ttype;
  logic [2:0]  etype;
  logic [7:0]  sid;
  logic [15:0] eid;
  logic [31:0] reqaddr, reqaddrh, ts;
  logic [DCW-1:0] drop_cnt;

  always #5 clk = ~clk;

  rv_iopmp_err_recorder #(.ADDR_WIDTH(64), .SID_WIDTH(8), .DROP_CNT_WIDTH(DCW)) dut (
    .clk_i(clk), .rst_i(rst), .err_valid_i(err_valid), .err_ttype_i(err_ttype),
    .err_etype_i(err_etype), .err_sid_i(err_sid), .err_eid_i(err_eid), .err_addr_i(err_addr),
    .ie_i(ie), .clr_ip_i(clr_ip), .clr_cnt_i(clr_cnt), .ip_o(ip), .pend_o(pend),
    .ttype_o(ttype), .etype_o(etype), .sid_o(sid), .eid_o(eid), .reqaddr_o(reqaddr),
    .reqaddrh_o(reqaddrh), .drop_cnt_o(drop_cnt), .irq_o(irq), .ts_o(ts)
  );

  typedef struct {
    logic [1:0]  tt;
    logic [2:0]  et;
    logic [7:0]  sid;
    logic [15:0] eid;
    logic [63:0] addr;
    logic [31:0] ts;
  } ent_t;

  typedef struct {
    logic        ip, pend, irq;
    logic [1:0]  tt;
    logic [2:0]  et;
    logic [7:0]  sid;
    logic [15:0] eid;
    logic [31:0] lo, hi, ts;
    int          drop;
  } exp_t;

  ent_t slots[$];
  exp_t exp_q[$];
  int   m_drop = 0;
  int   m_ts = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: pending errors are a FIFO of depth two; clear retires the oldest.
  task automatic go(input bit r, input bit e, input bit c, input bit cc, input bit ie_v,
                    input logic [1:0] tt, input logic [2:0] et, input logic [7:0] s,
                    input logic [15:0] id, input logic [63:0] a);
    ent_t n;
    exp_t x;
    bit   dropped;
    @(negedge clk);
    rst = r; err_valid = e; clr_ip = c; clr_cnt = cc; ie = ie_v;
    err_ttype = tt; err_etype = et; err_sid = s; err_eid = id; err_addr = a;
    dropped = 0;
    if (r) begin
      slots.delete();
      m_drop = 0;
    end else begin
      if (c && slots.size() > 0) void'(slots.pop_front());
      if (e) begin
        n = '{tt, et, s, id, a, m_ts};
        if (slots.size() < 2) slots.push_back(n);
        else dropped = 1;
      end
      if (cc) m_drop = dropped ? 1 : 0;
      else if (dropped && m_drop < DCW_MAX) m_drop++;
    end
    m_ts = r ? 0 : m_ts + 1;
    x = '{default: '0};
    x.drop = m_drop;
    if (slots.size() > 0) begin
      x.ip = 1; x.irq = ie_v; x.pend = (slots.size() == 2);
      x.tt = slots[0].tt; x.et = slots[0].et; x.sid = slots[0].sid; x.eid = slots[0].eid;
      x.lo = slots[0].addr[31:0]; x.hi = slots[0].addr[63:32];
`ifdef IOPMP_ERR_TIMESTAMP_EN
      x.ts = slots[0].ts;
`endif
    end
    exp_q.push_back(x);
  endtask

  task automatic idle(input bit ie_v);
    go(0, 0, 0, 0, ie_v, 0, 0, 0, 0, 0);
  endtask

  task automatic err(input bit c, input logic [15:0] id, input logic [63:0] a);
    go(0, 1, c, 0, 1, 2'd1, 3'd2, 8'h11, id, a);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("ip", 64'(ip), 64'(x.ip));
        check("pend", 64'(pend), 64'(x.pend));
        check("irq", 64'(irq), 64'(x.irq));
        check("ttype", 64'(ttype), 64'(x.tt));
        check("etype", 64'(etype), 64'(x.et));
        check("sid", 64'(sid), 64'(x.sid));
        check("eid", 64'(eid), 64'(x.eid));
        check("reqaddr", 64'(reqaddr), 64'(x.lo));
        check("reqaddrh", 64'(reqaddrh), 64'(x.hi));
        check("drop_cnt", 64'(drop_cnt), 64'(x.drop));
        check("ts", 64'(ts), 64'(x.ts));
      end
    end
  end

  initial begin
    rst = 1; err_valid = 0; clr_ip = 0; clr_cnt = 0; ie = 0;
    err_ttype = 0; err_etype = 0; err_sid = 0; err_eid = 0; err_addr = 0;
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // single capture, irq gating, clear
    go(0, 1, 0, 0, 1, 2'd2, 3'd3, 8'h5, 16'd7, 64'h1_8000_0040);
    idle(1);
    idle(0);
    idle(1);
    go(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // back-to-back A, B, C with one drop, then two clears
    err(0, 16'hA, 64'hAAAA_0000_1000);
    err(0, 16'hB, 64'hBBBB_0000_2000);
    err(0, 16'hC, 64'hCCCC_0000_3000);
    go(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    go(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // clear and new error together in CAP; extra clear in IDLE ignored
    go(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    err(0, 16'hA, 64'h0000_0001_0000_0010);
    err(1, 16'hD, 64'h0000_0002_0000_0020);
    idle(1);
    // saturation and clear-with-drop
    err(0, 16'h1, 64'h10);
    for (int i = 0; i < 6; i++) err(0, 16'(i + 2), 64'(i));
    go(0, 1, 0, 1, 1, 2'd3, 3'd1, 8'h22, 16'h99, 64'h99);
    go(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // clear and error together in CAP_PEND
    err(1, 16'hE, 64'hE);
    idle(1);
    // reset mid CAP_PEND, then a fresh capture
    go(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    err(0, 16'hF, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      go(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
         ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(1, 3)),
         3'($urandom), 8'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    end
    idle(1);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
